// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU memory bus: cpustate encodings,
// the memory responder state enum and the bus data width.
package cpu_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      CS_HALT  = 2'b00,
      CS_IN    = 2'b01,
      CS_CHECK = 2'b10,
      CS_RUN   = 2'b11
   } cpustate_t;

   typedef enum logic [1:0] {
      IDLE,
      INIT,
      WAIT,
      RESP
   } resp_state_t;

endpackage

// File: rtl/mem_array.sv
// Byte-wide single-port RAM: synchronous write, combinational read
// (distributed-RAM style), so the responder can register the read value
// in the same cycle it issues the access.
module mem_array
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   // Write port; NOTE: the array itself has no reset, clearing is done by the responder's sweep
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the CPU bus and the front-panel loader.
// Optional build macro MEM_BUSMON_EN adds rd_cnt/wr_cnt completion counters.
module mem_responder
   import cpu_pkg::*;
#(
   parameter int ADDR_W      = 6,
   parameter int WAIT_CYCLES = 1,
   parameter bit INIT_ZERO   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        cpustate,
   input  logic [15:0]       addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              read,
   input  logic              write,
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   output logic              busy,
   output logic              req_err,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic [DATA_W-1:0] ld_rdata
`ifdef MEM_BUSMON_EN
   ,
   output logic [15:0]       rd_cnt,
   output logic [15:0]       wr_cnt
`endif
);

   localparam logic [2:0]        CNT_LOAD  = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   resp_state_t       state;
   logic [2:0]        cnt;
   logic [ADDR_W-1:0] init_ptr;
   logic [ADDR_W-1:0] lat_addr;
   logic              lat_wr;
   logic [DATA_W-1:0] lat_wdata;

   logic              run;
   logic              accept;
   logic              issue;
   logic              issue_wr;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0] m_rdata;
   logic              addr_hi_unused;

   // Upper CPU address bits wrap away by design.
   assign addr_hi_unused = ^addr[15:ADDR_W];

   assign run    = (cpustate == CS_RUN);
   assign accept = (state == IDLE) && run && (read ^ write);
   // The array is accessed on the edge that enters RESP, so ready and rdata
   // appear together in the RESP cycle.
   assign issue    = (accept && (WAIT_CYCLES == 0)) ||
                     ((state == WAIT) && (cnt == 3'd0) && run);
   assign issue_wr = (state == IDLE) ? write : lat_wr;

   // Port arbitration: init sweep, then loader (by cpustate), then CPU.
   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred
      m_we    = 1'b0;
      m_addr  = lat_addr;
      m_wdata = lat_wdata;
      if (state == INIT) begin
         m_we    = 1'b1;
         m_addr  = init_ptr;
         m_wdata = '0;
      end else if (cpustate == CS_IN) begin
         m_we    = ld_we && (state == IDLE);
         m_addr  = ld_addr;
         m_wdata = ld_wdata;
      end else if (cpustate == CS_CHECK) begin
         m_addr  = ld_addr;
      end else if (state == IDLE) begin
         m_addr  = addr[ADDR_W-1:0];
         m_wdata = wdata;
         m_we    = issue && issue_wr;
      end else begin
         m_we    = issue && issue_wr;
      end
   end

   mem_array #(.ADDR_W(ADDR_W)) u_mem (
      .clk   (clk),
      .we    (m_we),
      .addr  (m_addr),
      .wdata (m_wdata),
      .rdata (m_rdata)
   );

   // Responder FSM with registered bus and loader outputs.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only
      if (rst) begin
         state     <= INIT_ZERO ? INIT : IDLE;
         busy      <= INIT_ZERO;
         cnt       <= '0;
         init_ptr  <= '0;
         lat_addr  <= '0;
         lat_wr    <= 1'b0;
         lat_wdata <= '0;
         rdata     <= '0;
         ready     <= 1'b0;
         req_err   <= 1'b0;
         ld_rdata  <= '0;
      end else begin
         ready <= issue;
         if (issue && !issue_wr) rdata <= m_rdata;
         if ((state == IDLE) && read && write) req_err <= 1'b1;
         if ((cpustate == CS_CHECK) && (state != INIT)) ld_rdata <= m_rdata;

         case (state)
            INIT: begin
               init_ptr <= init_ptr + ADDR_W'(1);
               if (init_ptr == LAST_ADDR) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            IDLE: begin
               if (accept) begin
                  lat_addr  <= addr[ADDR_W-1:0];
                  lat_wr    <= write;
                  lat_wdata <= wdata;
                  busy      <= 1'b1;
                  cnt       <= CNT_LOAD;
                  state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               if (!run) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (cnt == 3'd0) begin
                  state <= RESP;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_BUSMON_EN
   // Saturating counters of completed (ready-pulsed) CPU reads and writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else if (issue) begin
         if (!issue_wr && (rd_cnt != 16'hFFFF)) rd_cnt <= rd_cnt + 16'd1;
         if (issue_wr && (wr_cnt != 16'hFFFF))  wr_cnt <= wr_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed steps plus randomized
// CPU/loader traffic checked against a plain byte-array model.
module tb_mem_responder;
   import cpu_pkg::*;

   localparam int AW    = 6;
   localparam int DEPTH = 1 << AW;
   localparam int WAITC = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    cpustate;
   logic [15:0]   addr;
   logic [7:0]    wdata;
   logic          read;
   logic          write;
   logic [7:0]    rdata;
   logic          ready;
   logic          busy;
   logic          req_err;
   logic          ld_we;
   logic [AW-1:0] ld_addr;
   logic [7:0]    ld_wdata;
   logic [7:0]    ld_rdata;
`ifdef MEM_BUSMON_EN
   logic [15:0]   rd_cnt;
   logic [15:0]   wr_cnt;
`endif

   int           n_checks = 0;
   int           n_fail   = 0;
   byte unsigned model [DEPTH];
   logic [7:0]   last_rd;
   int           exp_rd;
   int           exp_wr;

   always #5 clk = ~clk;

   mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WAITC), .INIT_ZERO(1'b1)) dut (
      .clk      (clk),
      .rst      (rst),
      .cpustate (cpustate),
      .addr     (addr),
      .wdata    (wdata),
      .read     (read),
      .write    (write),
      .rdata    (rdata),
      .ready    (ready),
      .busy     (busy),
      .req_err  (req_err),
      .ld_we    (ld_we),
      .ld_addr  (ld_addr),
      .ld_wdata (ld_wdata),
      .ld_rdata (ld_rdata)
`ifdef MEM_BUSMON_EN
      ,
      .rd_cnt   (rd_cnt),
      .wr_cnt   (wr_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reset, check reset values, then measure the length of the init sweep.
   task automatic do_reset();
      int n;
      rst = 1'b1; read = 1'b0; write = 1'b0; ld_we = 1'b0;
      cpustate = CS_HALT; addr = '0; wdata = '0; ld_addr = '0; ld_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 32'(ready), 0);
      check("rst_rdata", 32'(rdata), 0);
      check("rst_req_err", 32'(req_err), 0);
      check("rst_ld_rdata", 32'(ld_rdata), 0);
      rst = 1'b0;
      n = 0;
      while (busy && n < 200) begin
         n++;
         @(posedge clk);
         #1;
      end
      check("init_busy_len", 32'(n), DEPTH);
      for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
      last_rd = 8'h00;
      exp_rd  = 0;
      exp_wr  = 0;
   endtask

   // One CPU transaction; strobe levels are scrambled while the DUT is busy.
   task automatic cpu_txn(input bit wr, input logic [15:0] a, input logic [7:0] d);
      int  lat;
      bit  rdy;
      int  idx;
      idx = int'(a) % DEPTH;
      cpustate = CS_RUN; addr = a; wdata = d; read = !wr; write = wr;
      lat = 0; rdy = 1'b0;
      while (!rdy && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
         if (ready) rdy = 1'b1;
         else begin
            addr  = 16'($urandom);
            wdata = 8'($urandom);
         end
      end
      read = 1'b0; write = 1'b0;
      check(wr ? "wr_latency" : "rd_latency", 32'(lat), WAITC + 1);
      if (wr) begin
         check("wr_rdata_hold", 32'(rdata), 32'(last_rd));
         model[idx] = d;
         exp_wr++;
      end else begin
         check("rd_data", 32'(rdata), 32'(model[idx]));
         last_rd = model[idx];
         exp_rd++;
      end
      @(posedge clk);
      #1;
      check("ready_one_cycle", 32'(ready), 0);
      check("busy_after_resp", 32'(busy), 0);
   endtask

   // Write accepted, then cpustate leaves RUN during the wait state.
   task automatic cpu_abort(input logic [15:0] a, input logic [7:0] d);
      cpustate = CS_RUN; addr = a; wdata = d; read = 1'b0; write = 1'b1;
      @(posedge clk);
      #1;
      check("abort_busy", 32'(busy), 1);
      check("abort_ready0", 32'(ready), 0);
      cpustate = CS_CHECK; write = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("abort_no_ready", 32'(ready), 0);
      end
      check("abort_idle", 32'(busy), 0);
      check("abort_rdata", 32'(rdata), 32'(last_rd));
   endtask

   task automatic ld_write(input logic [AW-1:0] a, input logic [7:0] d);
      cpustate = CS_IN; ld_we = 1'b1; ld_addr = a; ld_wdata = d;
      @(posedge clk);
      #1;
      ld_we = 1'b0;
      model[a] = d;
   endtask

   task automatic ld_check(input logic [AW-1:0] a);
      cpustate = CS_CHECK; ld_addr = a;
      @(posedge clk);
      #1;
      check("ld_rdata", 32'(ld_rdata), 32'(model[a]));
   endtask

   initial begin
      // Reset and zero sweep; reads after init return zero.
      do_reset();
      repeat (3) cpu_txn(1'b0, 16'($urandom), 8'h00);

      // Loader program load and readback; ld_we outside IN is ignored.
      ld_write(6'h05, 8'hA7);
      ld_check(6'h05);
      check("ld_rdata_A7", 32'(ld_rdata), 32'hA7);
      cpustate = CS_HALT; ld_we = 1'b1; ld_addr = 6'h05; ld_wdata = 8'h11;
      @(posedge clk);
      #1;
      ld_we = 1'b0;
      ld_check(6'h05);

      // Write then wrapped-address read.
      cpu_txn(1'b1, 16'h0003, 8'h3C);
      cpu_txn(1'b0, 16'h0043, 8'h00);
      check("wrap_rdata", 32'(rdata), 32'h3C);

      // Both strobes together: no accept, sticky error.
      cpustate = CS_RUN; read = 1'b1; write = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("both_no_ready", 32'(ready), 0);
         check("both_not_busy", 32'(busy), 0);
      end
      read = 1'b0; write = 1'b0;
      check("req_err_set", 32'(req_err), 1);

      // Aborted write leaves the old contents.
      cpu_txn(1'b1, 16'h0010, 8'h5A);
      cpu_abort(16'h0010, 8'hFF);
      cpu_txn(1'b0, 16'h0010, 8'h00);
      check("abort_old_value", 32'(rdata), 32'h5A);

      // Randomized CPU and loader traffic against the model.
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0:       cpu_txn(1'b0, 16'($urandom), 8'h00);
            1:       cpu_txn(1'b1, 16'($urandom), 8'($urandom));
            2:       ld_write(AW'($urandom), 8'($urandom));
            default: ld_check(AW'($urandom));
         endcase
      end
      check("req_err_sticky", 32'(req_err), 1);

      // Re-reset: error clears, memory is zeroed, then 3 reads, 2 writes, 1 abort.
      do_reset();
      cpu_txn(1'b0, 16'h0021, 8'h00);
      cpu_txn(1'b1, 16'h0021, 8'h99);
      cpu_txn(1'b0, 16'h0021, 8'h00);
      cpu_txn(1'b1, 16'hFFFF, 8'h42);
      cpu_abort(16'h0021, 8'hEE);
      cpu_txn(1'b0, 16'h003F, 8'h00);
      check("final_rdata", 32'(rdata), 32'h42);
`ifdef MEM_BUSMON_EN
      check("rd_cnt", 32'(rd_cnt), 32'(exp_rd));
      check("wr_cnt", 32'(wr_cnt), 32'(exp_wr));
      check("rd_cnt_3", 32'(rd_cnt), 3);
      check("wr_cnt_2", 32'(wr_cnt), 2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
